// File: rtl/qq_pkg.sv
// Shared types for the QuickQ request scheduler: FSM state encoding and op codes.
package qq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } qq_state_e;

  localparam logic OP_ENQ = 1'b0;
  localparam logic OP_DEQ = 1'b1;

  // An enqueue needs a free slot, a dequeue needs a stored entry.
  function automatic logic op_legal(input logic op, input logic full, input logic empty);
    return (op == OP_ENQ) ? !full : !empty;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector, search starting at a rotating pointer.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel;
  logic          found;
  int unsigned   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found      = 1'b1;
        gnt[sel]   = 1'b1;
        gnt_idx    = sel;
      end
    end
  end

  // Pointer moves just past the winner so it has lowest priority next round.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/qq_req_arbiter.sv
// Request scheduler sharing one QuickQ enqueue/dequeue port among NREQ requesters.
// Optional watchdog in WAIT enabled by defining QQ_ARB_TIMEOUT_EN.
module qq_req_arbiter
  import qq_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned KW      = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_op,
  input  logic [NREQ*KW-1:0]         req_key,
  output logic [NREQ-1:0]            req_ready,
  output logic                       q_enq,
  output logic                       q_deq,
  output logic [KW-1:0]              q_key,
  input  logic                       q_done,
  input  logic [KW-1:0]              q_dout,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [KW-1:0]              rsp_key,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("NREQ must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  qq_state_e     state_q, state_d;
  logic [IW-1:0] id_q, id_d;
  logic          op_q, op_d;
  logic [KW-1:0] key_q, key_d;
  logic          err_q, err_d;
  logic [CW-1:0] count_q, count_d;
  logic          q_enq_q, q_enq_d;
  logic          q_deq_q, q_deq_d;
  logic [KW-1:0] q_key_q, q_key_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic [KW-1:0] rsp_key_q, rsp_key_d;
  logic          rsp_err_q, rsp_err_d;

`ifdef QQ_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
  logic [WdW-1:0] wd_q, wd_d;
`endif

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            in_idle;
  logic            gnt_op;
  logic [KW-1:0]   gnt_key;
  logic            legal;

  assign in_idle = (state_q == StIdle);

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .advance(in_idle),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );

  // Grant is only offered while idle; reset masks it immediately.
  assign req_ready = (in_idle && !rst) ? gnt : '0;
  assign gnt_op    = req_op[gnt_idx];
  assign gnt_key   = req_key[32'(gnt_idx) * KW +: KW];
  assign legal     = op_legal(gnt_op, count_q == CountFull, count_q == '0);

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    op_d        = op_q;
    key_d       = key_q;
    err_d       = err_q;
    count_d     = count_q;
    q_enq_d     = 1'b0;
    q_deq_d     = 1'b0;
    q_key_d     = q_key_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_key_d   = rsp_key_q;
    rsp_err_d   = rsp_err_q;
`ifdef QQ_ARB_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          id_d    = gnt_idx;
          op_d    = gnt_op;
          key_d   = gnt_key;
          // Count is stable until WAIT, so legality is settled here and the strobe lands in ISSUE.
          err_d   = !legal;
          q_enq_d = legal && (gnt_op == OP_ENQ);
          q_deq_d = legal && (gnt_op == OP_DEQ);
          if (legal && (gnt_op == OP_ENQ)) begin
            q_key_d = gnt_key;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (err_q) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_key_d   = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          state_d = StWait;
        end
`ifdef QQ_ARB_TIMEOUT_EN
        wd_d = '0;
`endif
      end
      StWait: begin
        if (q_done) begin
          count_d     = (op_q == OP_ENQ) ? count_q + CW'(1) : count_q - CW'(1);
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_key_d   = (op_q == OP_DEQ) ? q_dout : key_q;
          rsp_err_d   = 1'b0;
          state_d     = StResp;
`ifdef QQ_ARB_TIMEOUT_EN
        end else if (wd_q == WdLast) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_key_d   = '0;
          rsp_err_d   = 1'b1;
          state_d     = StResp;
        end else begin
          wd_d = wd_q + WdW'(1);
`endif
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      id_q        <= '0;
      op_q        <= OP_ENQ;
      key_q       <= '0;
      err_q       <= 1'b0;
      count_q     <= '0;
      q_enq_q     <= 1'b0;
      q_deq_q     <= 1'b0;
      q_key_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_key_q   <= '0;
      rsp_err_q   <= 1'b0;
`ifdef QQ_ARB_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      op_q        <= op_d;
      key_q       <= key_d;
      err_q       <= err_d;
      count_q     <= count_d;
      q_enq_q     <= q_enq_d;
      q_deq_q     <= q_deq_d;
      q_key_q     <= q_key_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_key_q   <= rsp_key_d;
      rsp_err_q   <= rsp_err_d;
`ifdef QQ_ARB_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign q_enq     = q_enq_q;
  assign q_deq     = q_deq_q;
  assign q_key     = q_key_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_key   = rsp_key_q;
  assign rsp_err   = rsp_err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_qq_req_arbiter.sv
// Directed bench for qq_req_arbiter with a sorted min-queue model and a response scoreboard.
module tb_qq_req_arbiter;
  import qq_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned KW      = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] key;
    logic       err;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_key;
  logic [3:0]  req_ready;
  logic        q_enq;
  logic        q_deq;
  logic [7:0]  q_key;
  logic        q_done;
  logic [7:0]  q_dout;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_key;
  logic        rsp_err;
  logic [2:0]  count;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rsp_cyc = 0;
  bit   withhold = 0;
  rsp_t sb[$];
  rsp_t mon_e;
  logic [7:0] mq[$];
  int   ins_pos;

  qq_req_arbiter #(
    .NREQ   (NREQ),
    .KW     (KW),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_key  (req_key),
    .req_ready(req_ready),
    .q_enq    (q_enq),
    .q_deq    (q_deq),
    .q_key    (q_key),
    .q_done   (q_done),
    .q_dout   (q_dout),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_key  (rsp_key),
    .rsp_err  (rsp_err),
    .count    (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue model: sorted min-queue answering one cycle after each strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      q_done <= 1'b0;
      q_dout <= '0;
    end else begin
      q_done <= 1'b0;
      if (q_enq) begin
        ins_pos = 0;
        while (ins_pos < mq.size() && mq[ins_pos] <= q_key) ins_pos++;
        mq.insert(ins_pos, q_key);
        if (!withhold) q_done <= 1'b1;
      end else if (q_deq) begin
        if (mq.size() > 0) begin
          q_dout <= mq[0];
          mq.pop_front();
        end else begin
          q_dout <= '0;
        end
        if (!withhold) q_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", rsp_id, mon_e.id);
        check("rsp_key", rsp_key, mon_e.key);
        check("rsp_err", rsp_err, mon_e.err);
        rsp_cyc = cyc;
      end
    end
  end

  task automatic serve(input int id, input logic op, input logic [7:0] key,
                       input logic exp_err, input logic [7:0] exp_key, input int exp_lat);
    rsp_t e;
    int   n;
    int   gcyc;
    n = 0;
    #1;
    while (req_ready == 4'b0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", req_ready, 32'(1 << id));
    gcyc  = cyc;
    e.id  = 2'(id);
    e.key = exp_key;
    e.err = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    @(negedge clk);
    check("q_enq", q_enq, (op == OP_ENQ) && !exp_err);
    check("q_deq", q_deq, (op == OP_DEQ) && !exp_err);
    if ((op == OP_ENQ) && !exp_err) check("q_key", q_key, key);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rsp_seen", sb.size(), 0);
    sb.delete();
    check("rsp_latency", rsp_cyc - gcyc, exp_lat);
  endtask

  task automatic issue(input int id, input logic op, input logic [7:0] key,
                       input logic exp_err, input logic [7:0] exp_key, input int exp_lat);
    @(negedge clk);
    req_valid[id]          = 1'b1;
    req_op[id]             = op;
    req_key[id * 8 +: 8]   = key;
    serve(id, op, key, exp_err, exp_key, exp_lat);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_op    = '0;
    req_key   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_q_enq", q_enq, 0);
    check("rst_q_deq", q_deq, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_count", count, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Single enqueue from requester 2.
    issue(2, OP_ENQ, 8'h15, 1'b0, 8'h15, 3);
    check("count_after_first", count, 1);

    // Reset while the next op sits in WAIT: dropped silently, pointer back to 0.
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_op[2]    = OP_ENQ;
    req_key[23:16] = 8'h55;
    #1 check("wait_rst_grant", req_ready, 4'b0100);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    check("wait_rst_q_enq", q_enq, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("wait_rst_q_enq0", q_enq, 0);
    check("wait_rst_q_key", q_key, 0);
    check("wait_rst_rsp_valid", rsp_valid, 0);
    check("wait_rst_rsp_id", rsp_id, 0);
    check("wait_rst_rsp_key", rsp_key, 0);
    check("wait_rst_rsp_err", rsp_err, 0);
    check("wait_rst_count", count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // All four hold enqueues: round robin serves 0,1,2,3 and fills the queue.
    req_op    = 4'b0000;
    req_key   = 32'h24232221;
    req_valid = 4'b1111;
    serve(0, OP_ENQ, 8'h21, 1'b0, 8'h21, 3);
    serve(1, OP_ENQ, 8'h22, 1'b0, 8'h22, 3);
    serve(2, OP_ENQ, 8'h23, 1'b0, 8'h23, 3);
    serve(3, OP_ENQ, 8'h24, 1'b0, 8'h24, 3);
    check("count_full", count, 4);

    // Enqueue when full is rejected without a strobe.
    issue(1, OP_ENQ, 8'h77, 1'b1, 8'h00, 2);
    check("count_still_full", count, 4);

    // Dequeue returns the minimum key; dequeue when empty is rejected.
    pulse_reset();
    issue(0, OP_ENQ, 8'h30, 1'b0, 8'h30, 3);
    issue(1, OP_ENQ, 8'h10, 1'b0, 8'h10, 3);
    check("count_two", count, 2);
    issue(3, OP_DEQ, 8'h00, 1'b0, 8'h10, 3);
    check("count_after_deq", count, 1);
    issue(2, OP_DEQ, 8'h00, 1'b0, 8'h30, 3);
    check("count_empty", count, 0);
    issue(3, OP_DEQ, 8'h00, 1'b1, 8'h00, 2);
    check("count_still_empty", count, 0);

`ifdef QQ_ARB_TIMEOUT_EN
    // Withheld completion: watchdog reports an error after TIMEOUT WAIT cycles.
    withhold = 1'b1;
    issue(0, OP_ENQ, 8'h44, 1'b1, 8'h00, TIMEOUT + 2);
    check("count_after_timeout", count, 0);
    withhold = 1'b0;
`endif

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/qq_req_arbiter.md
# qq_req_arbiter

Request scheduler in front of the QuickQ priority-queue datapath. Shares the queue's single enqueue/dequeue port among NREQ requesters using round-robin arbitration and sequences one operation at a time into the control node. Tracks queue occupancy, rejects illegal operations (enqueue when full, dequeue when empty) and returns a tagged response for every accepted request.

## Interface
- NREQ, 4, number of requesters (2..8)
- KW, 8, key/data width
- DEPTH, 16, queue capacity in entries
- TIMEOUT, 64, watchdog limit in cycles (used only with QQ_ARB_TIMEOUT_EN)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_op  in  NREQ  per-requester op: 0 = enqueue, 1 = dequeue
- req_key  in  NREQ*KW  packed keys; requester i occupies bits [i*KW +: KW]
- req_ready  out  NREQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i]
- q_enq  out  1  one-cycle enqueue strobe to the control node
- q_deq  out  1  one-cycle dequeue strobe to the control node
- q_key  out  KW  key presented with q_enq
- q_done  in  1  control node reports that the issued operation is complete
- q_dout  in  KW  dequeued key; valid in the cycle q_done is high
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  $clog2(NREQ)  requester index of the response
- rsp_key  out  KW  dequeued key (dequeue) or echoed key (enqueue); 0 on error
- rsp_err  out  1  operation rejected (full/empty/timeout)
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is set, assert req_ready for the round-robin winner (combinational from req_valid and the pointer); latch id, op and key; go to ISSUE. Otherwise stay.
- Round robin: search starts at pointer; after every grant, pointer becomes winner+1 mod NREQ. Pointer is 0 after reset.
- ISSUE: legal enqueue (count < DEPTH) pulses q_enq with q_key = latched key; legal dequeue (count > 0) pulses q_deq; go to WAIT. Illegal op: no strobe, set error, go to RESP.
- WAIT: on q_done, capture q_dout for dequeues; count += 1 (enqueue) or -= 1 (dequeue); go to RESP.
- RESP: rsp_valid=1 with rsp_id, rsp_key, rsp_err for one cycle; go to IDLE.
- q_done outside WAIT is ignored. count never wraps: it is bounded to 0..DEPTH by the legality check.
- Requesters hold valid/op/key until granted; a deasserted request is never granted.

## Timing
- Reset values: req_ready=0, q_enq=0, q_deq=0, q_key=0, rsp_valid=0, rsp_id=0, rsp_key=0, rsp_err=0, count=0, state IDLE, pointer 0.
- Grant in cycle t (IDLE); strobe in t+1 (ISSUE); q_done sampled from t+2; rsp_valid in the cycle after q_done. If q_done arrives at t+2, the response is at t+3 and the next grant is at t+4.
- Illegal op: grant at t, rsp_valid with rsp_err=1 at t+2, no q_enq/q_deq.
- Reset asserted mid-operation: the in-flight op is dropped without a response; all outputs are forced to their reset values immediately. The queue is reset by the same rst, so count=0 is consistent.
- One operation in flight at most; throughput is at most one op per 4 cycles.

## Configuration
- QQ_ARB_TIMEOUT_EN defined: a watchdog counter runs in WAIT. If q_done has not arrived after TIMEOUT cycles, the FSM goes to RESP with rsp_err=1, and count is unchanged.
- QQ_ARB_TIMEOUT_EN undefined: no watchdog; WAIT holds indefinitely until q_done.

## Structure
- Shared package qq_pkg: the state enum (IDLE, ISSUE, WAIT, RESP) and the op localparams OP_ENQ=0 and OP_DEQ=1.
- Sub-module rr_arbiter (parameter NREQ) holds the pointer and produces the one-hot grant from a request vector. qq_req_arbiter instantiates it.

## Test plan
Bench parameters: NREQ=4, DEPTH=4, KW=8. The queue model raises q_done one cycle after a strobe and is otherwise a sorted min-queue.
- Reset, then requester 2 enqueues 0x15 -> req_ready=0b0100, q_enq pulse with q_key=0x15, rsp_valid with id=2 and err=0, count=1.
- All four requesters hold enqueue requests -> grants occur in order 0,1,2,3; count reaches 4.
- With count=4, requester 1 enqueues -> no q_enq, rsp_err=1 two cycles after grant, count stays 4.
- With keys 0x30 and 0x10 enqueued, requester 3 dequeues -> rsp_key=0x10, count decrements by 1. Dequeue at count=0 -> rsp_err=1, no q_deq.
- Assert rst while in WAIT -> no response, all outputs 0, and the next grant goes to requester 0.
- With QQ_ARB_TIMEOUT_EN and TIMEOUT=8, the model withholds q_done -> rsp_err=1 after 8 WAIT cycles, count unchanged.
